// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a hold-time limit that
// forces a handover once the owner has held the grant MAX_HOLD cycles while others wait.
module rr_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 4,
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 preempt
);

    localparam int             IW        = $clog2(N);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic            r_grant_valid;
    logic [IW-1:0]   r_grant_id;
    logic            r_preempt;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_hold_cnt;

    logic [N-1:0]    w_cand;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [N-1:0]    w_win_oh;
    logic [IW-1:0]   w_next_ptr;
    logic            w_take;
    logic            w_pre;
    logic            w_drop;

    // The current owner is always excluded from the search; in IDLE r_grant is zero.
    assign w_cand = request & ~r_grant;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_win_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_cand[(int'(r_ptr) + i) % N]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + i) % N);
            end
        end
        w_win_oh[w_win] = 1'b1;
        w_next_ptr      = IW'((int'(w_win) + 1) % N);
    end

    always_comb begin
        w_take = 1'b0;
        w_pre  = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            IDLE: begin
                w_take = w_found;
            end
            GRANT: begin
                if (!request[r_grant_id]) begin
                    w_take = w_found;
                    w_drop = !w_found;
                end else if (w_found && r_hold_cnt == HOLD_LAST) begin
                    w_take = 1'b1;
                    w_pre  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_preempt     <= 1'b0;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_preempt <= w_pre;
            if (w_take) begin
                r_state       <= GRANT;
                r_grant       <= w_win_oh;
                r_grant_valid <= 1'b1;
                r_grant_id    <= w_win;
                r_ptr         <= w_next_ptr;
                r_hold_cnt    <= '0;
            end else if (w_drop) begin
                r_state       <= IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_id    <= '0;
                r_hold_cnt    <= '0;
            end else if (r_state == GRANT && r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign preempt     = r_preempt;

endmodule
